rf_wb_arbiter: RTL and testbench

//  Write-back controller for the 32 x 32-bit register file built from REGISTER32 cells.
//  - Arbitrates two write-back requesters (0 = ALU pipe, 1 = load unit) onto the single write port.
//  - Drives the per-register load enables; r0 is never written.
//  - Keeps a busy-bit scoreboard and stalls issue on RAW/WAW hazards.
//  - Sits between the execute/memory stages and the register file.

---
 rtl/rf_wb_arbiter.sv | 98 +++++++++
 tb/tb_rf_wb_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter: round-robin grant of two requesters, one-hot load enables, busy scoreboard.
// Optional macro RF_WB_BYPASS_EN: sources matching the address granted this cycle do not stall issue.
module rf_wb_arbiter #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic            Clk,
  input  logic            Clr,
  input  logic            req0_valid,
  input  logic [AW-1:0]   req0_addr,
  input  logic [DW-1:0]   req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [AW-1:0]   req1_addr,
  input  logic [DW-1:0]   req1_data,
  output logic            req1_ready,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rs1,
  input  logic [AW-1:0]   iss_rs2,
  input  logic [AW-1:0]   iss_rd,
  output logic            iss_stall,
  output logic [NREG-1:0] rf_le,
  output logic [DW-1:0]   rf_wdata,
  output logic [NREG-1:0] busy_vec
);

  logic            rr_ptr;
  logic [NREG-1:0] busy;
  logic            grant0;
  logic            grant1;
  logic            hs;
  logic            contested;
  logic [AW-1:0]   wb_addr;
  logic [DW-1:0]   wb_data;
  logic            src1_hit;
  logic            src2_hit;
  logic            issue_ok;
  logic [NREG-1:0] busy_nxt;
  logic [NREG-1:0] le_nxt;

  // Grants are masked while Clr is high so nothing handshakes during reset.
  always_comb begin
    contested = req0_valid & req1_valid;
    grant0    = ~Clr & req0_valid & (~req1_valid | ~rr_ptr);
    grant1    = ~Clr & req1_valid & (~req0_valid | rr_ptr);
    hs        = grant0 | grant1;
    wb_addr   = grant1 ? req1_addr : req0_addr;
    wb_data   = grant1 ? req1_data : req0_data;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
`ifdef RF_WB_BYPASS_EN
    src1_hit = busy[iss_rs1] & ~(hs & (wb_addr == iss_rs1));
    src2_hit = busy[iss_rs2] & ~(hs & (wb_addr == iss_rs2));
`else
    src1_hit = busy[iss_rs1];
    src2_hit = busy[iss_rs2];
`endif
    iss_stall = iss_valid & (src1_hit | src2_hit | busy[iss_rd]);
    issue_ok  = iss_valid & ~iss_stall & (iss_rd != '0);
  end

  // Clear first, then set, so a new producer wins over a retiring one.
  always_comb begin
    busy_nxt = busy;
    if (hs)
      busy_nxt[wb_addr] = 1'b0;
    if (issue_ok)
      busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
    le_nxt = '0;
    if (hs && (wb_addr != '0))
      le_nxt[wb_addr] = 1'b1;
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      rr_ptr   <= 1'b0;
      rf_le    <= '0;
      rf_wdata <= '0;
      busy     <= '0;
    end else begin
      rf_le <= le_nxt;
      busy  <= busy_nxt;
      if (hs)
        rf_wdata <= wb_data;
      if (contested && hs)
        rr_ptr <= grant0;
    end
  end

  assign busy_vec = busy;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_rf_wb_arbiter;

  logic        Clk;
  logic        Clr;
  logic        req0_valid;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        iss_valid;
  logic [4:0]  iss_rs1;
  logic [4:0]  iss_rs2;
  logic [4:0]  iss_rd;
  logic        iss_stall;
  logic [31:0] rf_le;
  logic [31:0] rf_wdata;
  logic [31:0] busy_vec;

  bit run;
  int n_checks;
  int n_pass;

  rf_wb_arbiter dut (
    .Clk(Clk), .Clr(Clr),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_stall(iss_stall), .rf_le(rf_le), .rf_wdata(rf_wdata), .busy_vec(busy_vec)
  );

  initial begin
    Clk = 1'b0;
    run = 1'b1;
    forever begin
      #5;
      if (run) Clk = ~Clk;
    end
  end

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    iss_valid  = 1'b0; iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    idle_inputs();
    Clr = 1'b1;
    #2;
    Clr = 1'b0;
  endtask

  // T1 + T6: asynchronous reset with the clock stopped, and round-robin pointer restored.
  task automatic test_reset();
    do_reset();
    for (int r = 8; r <= 11; r++) begin
      @(negedge Clk);
      req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h1234_5678;
      req1_valid = (r == 11); req1_addr = 5'd4; req1_data = 32'h0;
      iss_valid = 1'b1; iss_rs1 = '0; iss_rs2 = '0; iss_rd = 5'(r);
      @(posedge Clk);
    end
    #1;
    n_checks++;
    if (busy_vec !== 32'h0000_0F00) $display("FAIL pre_reset_busy: got %h want %h", busy_vec, 32'h0000_0F00);
    else n_pass++;
    n_checks++;
    if (rf_le !== 32'h8) $display("FAIL pre_reset_le: got %h want %h", rf_le, 32'h8);
    else n_pass++;
    req1_valid = 1'b0;
    iss_valid = 1'b0;
    #1;
    run = 1'b0;
    #7;
    Clr = 1'b1;
    #1;
    n_checks++;
    if (rf_le !== 32'h0) $display("FAIL async_reset_le: got %h want 0", rf_le);
    else n_pass++;
    n_checks++;
    if (rf_wdata !== 32'h0) $display("FAIL async_reset_wdata: got %h want 0", rf_wdata);
    else n_pass++;
    n_checks++;
    if (busy_vec !== 32'h0) $display("FAIL async_reset_busy: got %h want 0", busy_vec);
    else n_pass++;
    n_checks++;
    if (req0_ready !== 1'b0) $display("FAIL reset_no_grant: got %b want 0", req0_ready);
    else n_pass++;
    #3;
    req1_valid = 1'b1; req1_addr = 5'd2;
    Clr = 1'b0;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10)
      $display("FAIL first_contested_after_reset: got %b want 10", {req0_ready, req1_ready});
    else n_pass++;
    run = 1'b1;
    @(negedge Clk);
    idle_inputs();
  endtask

  // T2: both valid every cycle -> grants alternate, rf_le follows one cycle later.
  task automatic test_alternate();
    logic [1:0]  exp_rdy;
    logic [31:0] exp_le;
    logic [31:0] exp_wd;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hAAAA_0001;
      req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h5555_0002;
      #1;
      exp_rdy = (i % 2 == 0) ? 2'b10 : 2'b01;
      n_checks++;
      if ({req0_ready, req1_ready} !== exp_rdy)
        $display("FAIL alt_grant[%0d]: got %b want %b", i, {req0_ready, req1_ready}, exp_rdy);
      else n_pass++;
      @(posedge Clk);
      #1;
      exp_le = (i % 2 == 0) ? 32'h8 : 32'h10;
      exp_wd = (i % 2 == 0) ? 32'hAAAA_0001 : 32'h5555_0002;
      n_checks++;
      if (rf_le !== exp_le || rf_wdata !== exp_wd)
        $display("FAIL alt_write[%0d]: got le=%h wd=%h want le=%h wd=%h", i, rf_le, rf_wdata, exp_le, exp_wd);
      else n_pass++;
    end
    @(negedge Clk);
    idle_inputs();
    @(posedge Clk);
    #1;
    n_checks++;
    if (rf_le !== 32'h0 || rf_wdata !== 32'h5555_0002)
      $display("FAIL idle_le_clear: got le=%h wd=%h want le=0 wd=55550002", rf_le, rf_wdata);
    else n_pass++;
  endtask

  // T3: write-back to r0 handshakes but enables nothing.
  task automatic test_zero_addr();
    do_reset();
    @(negedge Clk);
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b01)
      $display("FAIL r0_grant: got %b want 01", {req0_ready, req1_ready});
    else n_pass++;
    @(posedge Clk);
    #1;
    n_checks++;
    if (rf_le !== 32'h0 || busy_vec !== 32'h0)
      $display("FAIL r0_no_write: got le=%h busy=%h want 0/0", rf_le, busy_vec);
    else n_pass++;
    @(negedge Clk);
    idle_inputs();
  endtask

  // T4: RAW hazard on r7 resolved by a write-back three cycles later.
  task automatic test_hazard();
    logic        exp_stall;
    logic [31:0] exp_busy;
    do_reset();
    @(negedge Clk);
    iss_valid = 1'b1; iss_rd = 5'd7;
    #1;
    n_checks++;
    if (iss_stall !== 1'b0) $display("FAIL raw_producer_issue: got %b want 0", iss_stall);
    else n_pass++;
    @(posedge Clk);
    #1;
    n_checks++;
    if (busy_vec !== 32'h80) $display("FAIL raw_busy_set: got %h want 80", busy_vec);
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      iss_valid = 1'b1; iss_rs1 = 5'd7; iss_rs2 = 5'd0; iss_rd = 5'd1;
      req0_valid = (c == 2); req0_addr = 5'd7; req0_data = 32'h0000_0777;
      #1;
`ifdef RF_WB_BYPASS_EN
      exp_stall = (c != 2);
`else
      exp_stall = 1'b1;
`endif
      n_checks++;
      if (iss_stall !== exp_stall) $display("FAIL raw_stall[%0d]: got %b want %b", c, iss_stall, exp_stall);
      else n_pass++;
      @(posedge Clk);
    end
    #1;
`ifdef RF_WB_BYPASS_EN
    exp_busy = 32'h2;
`else
    exp_busy = 32'h0;
`endif
    n_checks++;
    if (busy_vec !== exp_busy || rf_le !== 32'h80)
      $display("FAIL raw_after_wb: got busy=%h le=%h want busy=%h le=80", busy_vec, rf_le, exp_busy);
    else n_pass++;
    @(negedge Clk);
    idle_inputs();
    iss_valid = 1'b1; iss_rs1 = 5'd7; iss_rd = 5'd2;
    #1;
    n_checks++;
    if (iss_stall !== 1'b0) $display("FAIL raw_released: got %b want 0", iss_stall);
    else n_pass++;
    @(negedge Clk);
    idle_inputs();
  endtask

  // T5: issue rd=9 coinciding with a write-back to 9 leaves r9 busy.
  task automatic test_set_wins();
    do_reset();
    @(negedge Clk);
    iss_valid = 1'b1; iss_rd = 5'd9;
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h9999_0009;
    #1;
    n_checks++;
    if (iss_stall !== 1'b0 || req0_ready !== 1'b1)
      $display("FAIL setwins_comb: got stall=%b rdy=%b want 0/1", iss_stall, req0_ready);
    else n_pass++;
    @(posedge Clk);
    #1;
    n_checks++;
    if (busy_vec !== 32'h200 || rf_le !== 32'h200)
      $display("FAIL setwins_busy: got busy=%h le=%h want 200/200", busy_vec, rf_le);
    else n_pass++;
    @(negedge Clk);
    idle_inputs();
  endtask

  // Random traffic checked against a cycle-level model of the documented rules.
  task automatic test_random();
    bit          bm[32];
    int          rr;
    int          winner;
    logic [31:0] exp_le;
    logic [31:0] exp_wd;
    logic [31:0] bvec;
    logic        exp_stall;
    logic        s1;
    logic        s2;
    int          waddr;
    logic [31:0] wdata;
    do_reset();
    for (int k = 0; k < 32; k++) bm[k] = 1'b0;
    rr = 0; exp_le = '0; exp_wd = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge Clk);
      bvec = '0;
      for (int k = 0; k < 32; k++) bvec[k] = bm[k];
      n_checks++;
      if (rf_le !== exp_le || rf_wdata !== exp_wd || busy_vec !== bvec)
        $display("FAIL rand_state[%0d]: got le=%h wd=%h busy=%h want le=%h wd=%h busy=%h",
                 cyc, rf_le, rf_wdata, busy_vec, exp_le, exp_wd, bvec);
      else n_pass++;
      req0_valid = ($urandom_range(99, 0) < 50);
      req0_addr  = 5'($urandom_range(15, 0));
      req0_data  = $urandom;
      req1_valid = ($urandom_range(99, 0) < 50);
      req1_addr  = 5'($urandom_range(15, 0));
      req1_data  = $urandom;
      iss_valid  = ($urandom_range(99, 0) < 60);
      iss_rs1    = 5'($urandom_range(15, 0));
      iss_rs2    = 5'($urandom_range(15, 0));
      iss_rd     = 5'($urandom_range(15, 0));
      #1;
      if (req0_valid && req1_valid) winner = rr;
      else if (req0_valid) winner = 0;
      else if (req1_valid) winner = 1;
      else winner = -1;
      waddr = (winner == 1) ? int'(req1_addr) : int'(req0_addr);
      wdata = (winner == 1) ? req1_data : req0_data;
      s1 = bm[iss_rs1];
      s2 = bm[iss_rs2];
`ifdef RF_WB_BYPASS_EN
      if (winner >= 0 && waddr == int'(iss_rs1)) s1 = 1'b0;
      if (winner >= 0 && waddr == int'(iss_rs2)) s2 = 1'b0;
`endif
      exp_stall = iss_valid && (s1 || s2 || bm[iss_rd]);
      n_checks++;
      if (req0_ready !== (winner == 0) || req1_ready !== (winner == 1) || iss_stall !== exp_stall)
        $display("FAIL rand_comb[%0d]: got r0=%b r1=%b stall=%b want r0=%b r1=%b stall=%b",
                 cyc, req0_ready, req1_ready, iss_stall, winner == 0, winner == 1, exp_stall);
      else n_pass++;
      if (winner >= 0) begin
        exp_le = (waddr == 0) ? 32'h0 : (32'h1 << waddr);
        exp_wd = wdata;
        bm[waddr] = 1'b0;
        if (req0_valid && req1_valid) rr = 1 - winner;
      end else begin
        exp_le = 32'h0;
      end
      if (iss_valid && !exp_stall && iss_rd != 5'd0) bm[iss_rd] = 1'b1;
      bm[0] = 1'b0;
      @(posedge Clk);
    end
    @(negedge Clk);
    idle_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    idle_inputs();
    Clr = 1'b1;
    #1;
    n_checks++;
    if (rf_le !== 32'h0 || rf_wdata !== 32'h0 || busy_vec !== 32'h0)
      $display("FAIL initial_reset: got le=%h wd=%h busy=%h want all 0", rf_le, rf_wdata, busy_vec);
    else n_pass++;
    repeat (2) @(posedge Clk);
    #1;
    Clr = 1'b0;
    test_reset();
    test_alternate();
    test_zero_addr();
    test_hazard();
    test_set_wins();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
